dom_share_codec: RTL and testbench
==================================

DOM_SHARE_CODEC -- requirements
Module: dom_share_codec

Interface
REQ-001 Parameter: W, default 8, operand width in bits; legal range 1..10 (3W <= 32).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset is synchronous and active-low.
REQ-004 seed_load  input  1  load LFSR from seed this cycle.
REQ-005 seed  input  32  LFSR seed value.
REQ-006 in_valid  input  1  unmasked operand pair valid.
REQ-007 in_ready  output  1  codec can accept an operand pair.
REQ-008 in_a  input  W  unmasked operand a.
REQ-009 in_b  input  W  unmasked operand b.
REQ-010 a_sh0, a_sh1  output  W each  Boolean shares of a, driving the gadget's port_a.
REQ-011 b_sh0, b_sh1  output  W each  Boolean shares of b, driving the gadget's port_b.
REQ-012 r_fresh  output  W  fresh randomness, one bit per gadget instance.
REQ-013 c_sh0, c_sh1  input  W each  product shares returned by W parallel first-order DOM-indep AND gadgets, each with 1 register stage.
REQ-014 out_valid  output  1  unmasked result valid.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 out_c  output  W  unmasked result, equal to in_a AND in_b.

Function
REQ-017 FSM states: IDLE, SHARE, CAPT, UNMASK, OUT; only IDLE asserts in_ready.
REQ-018 IDLE -> SHARE when in_valid=1; on that edge the codec registers ma=L[W-1:0], mb=L[2W-1:W], r=L[3W-1:2W], where L is the current LFSR state.
REQ-019 Same edge: a_sh0 <= in_a^ma, a_sh1 <= ma, b_sh0 <= in_b^mb, b_sh1 <= mb, r_fresh <= r; all are registered outputs.
REQ-020 SHARE -> CAPT unconditionally; share and r_fresh outputs are held stable through SHARE and CAPT.
REQ-021 CAPT: c_sh0 and c_sh1 are captured into two separate registers with no combinational mixing of shares before the registers; then -> UNMASK.
REQ-022 UNMASK: out_c <= captured c0 XOR captured c1; a_sh*, b_sh* and r_fresh are cleared to 0 on the same edge; then -> OUT.
REQ-023 OUT: out_valid=1, out_c stable; -> IDLE on the edge where out_ready=1; holds indefinitely otherwise.
REQ-024 Latency: accept on edge k; out_valid first high in the cycle after edge k+3; max throughput is one operation per 5 cycles.
REQ-025 LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, advances one step every cycle not in reset.
REQ-026 seed_load=1 overrides stepping: L <= seed, or 32'h0000_0001 if seed==0; the all-zero state is never reachable.
REQ-027 Simultaneous seed_load and acceptance: masks come from the pre-load L; the load applies to the next state.
REQ-028 in_valid while not in IDLE is ignored; in_a and in_b are not sampled.
REQ-029 out_valid is never high outside OUT; out_c keeps its value after leaving OUT until the next UNMASK.

Reset
REQ-030 rst_n=0 at an edge: state<=IDLE, L<=32'h0000_0001, all share outputs, r_fresh, captured shares and out_c <= 0, out_valid=0; in_ready=1 in the first cycle after release.
REQ-031 Reset mid-operation (any state) aborts the operation with no output transaction; rst_n has priority over seed_load.

Structure
REQ-032 Shared package dom_codec_pkg holds: the state enum, LFSR tap constant 32'h8020_0003, reset seed 32'h0000_0001, and the W legality limit.
REQ-033 One sub-module, dom_lfsr32 (clk, rst_n, load, seed, state), implements REQ-025/026; all other logic stays in dom_share_codec.

Verification
REQ-034 Reset, then idle 3 cycles -> in_ready=1, out_valid=0, all share outputs 0, and L steps from 1 per the polynomial every cycle.
REQ-035 Bench wires W=8 behavioural DOM-indep gadgets. Load seed 32'h1234_5678, then a=8'hA5, b=8'h3C -> out_c=8'h24, out_valid high 4 cycles after accept; a_sh0^a_sh1=8'hA5 and a_sh1=L[7:0] at accept.
REQ-036 Hold out_ready=0 for 6 cycles in OUT -> out_valid and out_c stay constant, in_ready=0, and a second in_valid is ignored.
REQ-037 seed_load with seed=0 -> L=1 the next cycle; seed_load on the accept edge -> masks equal the pre-load L.
REQ-038 rst_n=0 during CAPT -> IDLE, no out_valid pulse; next operation a=8'hFF, b=8'h0F -> out_c=8'h0F.
REQ-039 Random stress of 10^4 operations with random out_ready -> out_c == a&b every time; the bench records r_fresh and ma for leakage-evaluation tooling.

Source files
------------

// File: rtl/dom_codec_pkg.sv
// Shared definitions for the DOM share codec: FSM states, LFSR constants and
// the operand-width limit.
package dom_codec_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHARE  = 3'd1,
        CAPT   = 3'd2,
        UNMASK = 3'd3,
        OUT    = 3'd4
    } state_t;

    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
    localparam logic [31:0] LFSR_TAPS       = 32'h8020_0003;
    localparam logic [31:0] LFSR_RESET_SEED = 32'h0000_0001;

    // Three W-bit fields (two masks and the fresh bit vector) come from one
    // 32-bit LFSR word, so W may not exceed 10.
    localparam int W_MAX = 10;

    // One Galois step: shift right and fold the taps back in on a carry-out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        lfsr_step = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/dom_lfsr32.sv
// 32-bit Galois LFSR that supplies masks and fresh randomness to the codec.
// A zero seed is replaced by the reset seed so the lock-up state never occurs.
module dom_lfsr32
    import dom_codec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    // Reset beats load, load beats stepping; otherwise advance every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LFSR_RESET_SEED;
        end else if (load) begin
            state <= (seed == 32'h0000_0000) ? LFSR_RESET_SEED : seed;
        end else begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/dom_share_codec.sv
// Boolean-masking front/back end for W parallel first-order DOM-indep AND
// gadgets: splits an operand pair into shares, waits out the gadget register
// stage, captures the two product shares separately and recombines them.
module dom_share_codec
    import dom_codec_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_load,
    input  logic [31:0]  seed,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [W-1:0] a_sh0,
    output logic [W-1:0] a_sh1,
    output logic [W-1:0] b_sh0,
    output logic [W-1:0] b_sh1,
    output logic [W-1:0] r_fresh,
    input  logic [W-1:0] c_sh0,
    input  logic [W-1:0] c_sh1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_c
);

    state_t       state;
    state_t       state_next;
    logic [31:0]  lfsr;
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    logic [W-1:0] rnd;
    logic [W-1:0] c0_cap;
    logic [W-1:0] c1_cap;
    logic         accept;
    logic         lfsr_unused;

    dom_lfsr32 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (seed_load),
        .seed  (seed),
        .state (lfsr)
    );

    // Masks are taken from the LFSR value present before the edge, so a
    // simultaneous seed load only affects later operations.
    assign ma          = lfsr[W-1:0];
    assign mb          = lfsr[2*W-1:W];
    assign rnd         = lfsr[3*W-1:2*W];
    assign lfsr_unused = ^lfsr;
    assign accept      = (state == IDLE) && in_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SHARE;
            end
            SHARE:  state_next = CAPT;
            CAPT:   state_next = UNMASK;
            UNMASK: state_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Share generation on accept; held through the gadget latency, then wiped
    // so no share of a finished operand lingers on the gadget inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh0   <= '0;
            a_sh1   <= '0;
            b_sh0   <= '0;
            b_sh1   <= '0;
            r_fresh <= '0;
        end else if (accept) begin
            a_sh0   <= in_a ^ ma;
            a_sh1   <= ma;
            b_sh0   <= in_b ^ mb;
            b_sh1   <= mb;
            r_fresh <= rnd;
        end else if (state == UNMASK) begin
            a_sh0   <= '0;
            a_sh1   <= '0;
            b_sh0   <= '0;
            b_sh1   <= '0;
            r_fresh <= '0;
        end
    end

    // Capture each product share into its own register; the shares are never
    // combined before they are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c0_cap <= '0;
            c1_cap <= '0;
        end else if (state == CAPT) begin
            c0_cap <= c_sh0;
            c1_cap <= c_sh1;
        end
    end

    // Unmask the registered shares; the result persists until the next unmask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_c <= '0;
        end else if (state == UNMASK) begin
            out_c <= c0_cap ^ c1_cap;
        end
    end

endmodule

// File: tb/tb_dom_share_codec.sv
// Directed bench for dom_share_codec with behavioural W=8 DOM-indep gadgets.
`timescale 1ns/1ps
module tb_dom_share_codec;

    localparam int W = 8;
    localparam int N_STRESS = 10000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         seed_load = 1'b0;
    logic [31:0]  seed = 32'h0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] a_sh0, a_sh1, b_sh0, b_sh1, r_fresh;
    logic [W-1:0] c_sh0, c_sh1;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_c;

    int total = 0;
    int bad   = 0;

    logic [31:0]  lm = 32'h1;
    logic [W-1:0] rec_ma [N_STRESS];
    logic [W-1:0] rec_r  [N_STRESS];

    // Behavioural DOM-indep AND gadgets, one register stage on the cross terms.
    logic [W-1:0] g0_p = '0;
    logic [W-1:0] g1_p = '0;

    always @(posedge clk) begin
        g0_p <= (a_sh0 & b_sh1) ^ r_fresh;
        g1_p <= (a_sh1 & b_sh0) ^ r_fresh;
    end

    assign c_sh0 = (a_sh0 & b_sh0) ^ g0_p;
    assign c_sh1 = (a_sh1 & b_sh1) ^ g1_p;

    always #5 clk = ~clk;

    dom_share_codec #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .a_sh0     (a_sh0),
        .a_sh1     (a_sh1),
        .b_sh0     (b_sh0),
        .b_sh1     (b_sh1),
        .r_fresh   (r_fresh),
        .c_sh0     (c_sh0),
        .c_sh1     (c_sh1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c)
    );

    function automatic logic [31:0] step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Advance one clock, keeping the reference LFSR value in step.
    task automatic tick();
        logic [31:0] nx;
        if (!rst_n)         nx = 32'h1;
        else if (seed_load) nx = (seed == 32'h0) ? 32'h1 : seed;
        else                nx = step(lm);
        @(posedge clk);
        lm = nx;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_l [3];
        exp_l[0] = 32'h8020_0003;
        exp_l[1] = 32'hC030_0002;
        exp_l[2] = 32'h6018_0001;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
        total++; if ({a_sh0, a_sh1, b_sh0, b_sh1, r_fresh, out_c} !== 48'h0) begin bad++; $display("FAIL rst_outputs got=%h exp=0", {a_sh0, a_sh1, b_sh0, b_sh1, r_fresh, out_c}); end
        total++; if (dut.u_lfsr.state !== 32'h1) begin bad++; $display("FAIL rst_lfsr got=%h exp=00000001", dut.u_lfsr.state); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (dut.u_lfsr.state !== exp_l[i]) begin bad++; $display("FAIL idle_lfsr%0d got=%h exp=%h", i, dut.u_lfsr.state, exp_l[i]); end
            total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL idle_hs%0d got=%b exp=10", i, {in_ready, out_valid}); end
        end
    endtask

    task automatic test_basic();
        seed_load = 1'b1;
        seed = 32'h1234_5678;
        tick();
        seed_load = 1'b0;
        total++; if (dut.u_lfsr.state !== 32'h1234_5678) begin bad++; $display("FAIL seed_load got=%h exp=12345678", dut.u_lfsr.state); end
        in_valid = 1'b1;
        in_a = 8'hA5;
        in_b = 8'h3C;
        tick();
        in_valid = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        total++; if ({a_sh0, a_sh1, b_sh0, b_sh1, r_fresh} !== 40'hDD_78_6A_56_34) begin bad++; $display("FAIL basic_shares got=%h exp=dd786a5634", {a_sh0, a_sh1, b_sh0, b_sh1, r_fresh}); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_busy got=%0h exp=0", in_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid%0d got=%0h exp=0", i, out_valid); end
            total++; if ({a_sh0, a_sh1, b_sh0, b_sh1, r_fresh} !== 40'hDD_78_6A_56_34) begin bad++; $display("FAIL basic_hold%0d got=%h exp=dd786a5634", i, {a_sh0, a_sh1, b_sh0, b_sh1, r_fresh}); end
        end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%0h exp=1", out_valid); end
        total++; if (out_c !== 8'h24) begin bad++; $display("FAIL basic_out_c got=%h exp=24", out_c); end
        total++; if ({a_sh0, a_sh1, b_sh0, b_sh1, r_fresh} !== 40'h0) begin bad++; $display("FAIL basic_clear got=%h exp=0", {a_sh0, a_sh1, b_sh0, b_sh1, r_fresh}); end
    endtask

    task automatic test_hold();
        in_valid = 1'b1;
        in_a = 8'h11;
        in_b = 8'h77;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if ({out_valid, in_ready, out_c} !== {1'b1, 1'b0, 8'h24}) begin bad++; $display("FAIL hold%0d got=%h exp=224", i, {out_valid, in_ready, out_c}); end
            total++; if ({a_sh0, a_sh1, b_sh0, b_sh1} !== 32'h0) begin bad++; $display("FAIL hold_shares%0d got=%h exp=0", i, {a_sh0, a_sh1, b_sh0, b_sh1}); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL hold_release got=%b exp=01", {out_valid, in_ready}); end
        total++; if (out_c !== 8'h24) begin bad++; $display("FAIL hold_keep_c got=%h exp=24", out_c); end
        tick();
        total++; if ({in_ready, a_sh0, a_sh1} !== 17'h1_0000) begin bad++; $display("FAIL hold_ignored got=%h exp=10000", {in_ready, a_sh0, a_sh1}); end
    endtask

    task automatic test_seed();
        seed_load = 1'b1;
        seed = 32'h0;
        tick();
        seed_load = 1'b0;
        total++; if (dut.u_lfsr.state !== 32'h1) begin bad++; $display("FAIL seed_zero got=%h exp=00000001", dut.u_lfsr.state); end
        seed_load = 1'b1;
        seed = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        in_a = 8'h3F;
        in_b = 8'hF3;
        tick();
        seed_load = 1'b0;
        in_valid = 1'b0;
        total++; if ({a_sh0, a_sh1, b_sh0, b_sh1, r_fresh} !== 40'h3E_01_F3_00_00) begin bad++; $display("FAIL seed_accept_masks got=%h exp=3e01f30000", {a_sh0, a_sh1, b_sh0, b_sh1, r_fresh}); end
        total++; if (dut.u_lfsr.state !== 32'hDEAD_BEEF) begin bad++; $display("FAIL seed_accept_load got=%h exp=deadbeef", dut.u_lfsr.state); end
        out_ready = 1'b1;
        for (int i = 0; i < 8 && out_valid !== 1'b1; i++) tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL seed_timeout got=%0h exp=1", out_valid); end
        total++; if (out_c !== 8'h33) begin bad++; $display("FAIL seed_out_c got=%h exp=33", out_c); end
        tick();
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL seed_idle got=%0h exp=1", in_ready); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_a = 8'h55;
        in_b = 8'h55;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        seed_load = 1'b1;
        seed = 32'h0000_00AA;
        tick();
        rst_n = 1'b1;
        seed_load = 1'b0;
        total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL mid_rst_hs got=%b exp=10", {in_ready, out_valid}); end
        total++; if ({a_sh0, a_sh1, b_sh0, b_sh1, r_fresh, out_c} !== 48'h0) begin bad++; $display("FAIL mid_rst_outputs got=%h exp=0", {a_sh0, a_sh1, b_sh0, b_sh1, r_fresh, out_c}); end
        total++; if (dut.u_lfsr.state !== 32'h1) begin bad++; $display("FAIL mid_rst_priority got=%h exp=00000001", dut.u_lfsr.state); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_pulse%0d got=%0h exp=0", i, out_valid); end
        end
        in_valid = 1'b1;
        in_a = 8'hFF;
        in_b = 8'h0F;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8 && out_valid !== 1'b1; i++) tick();
        total++; if ({out_valid, out_c} !== {1'b1, 8'h0F}) begin bad++; $display("FAIL mid_next_op got=%h exp=10f", {out_valid, out_c}); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_stress();
        logic [W-1:0] a, b;
        logic [31:0]  l_pre;
        logic         hs;
        int           guard;
        int           ones_ma = 0;
        int           ones_r = 0;
        for (int n = 0; n < N_STRESS; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            in_a = a;
            in_b = b;
            in_valid = 1'b1;
            l_pre = lm;
            tick();
            in_valid = 1'b0;
            rec_ma[n] = a_sh1;
            rec_r[n]  = r_fresh;
            total++; if ({a_sh0 ^ a_sh1, a_sh1, r_fresh} !== {a, l_pre[7:0], l_pre[23:16]}) begin bad++; $display("FAIL stress_share%0d got=%h exp=%h", n, {a_sh0 ^ a_sh1, a_sh1, r_fresh}, {a, l_pre[7:0], l_pre[23:16]}); end
            for (int i = 0; i < 6 && out_valid !== 1'b1; i++) tick();
            total++; if ({out_valid, out_c} !== {1'b1, a & b}) begin bad++; $display("FAIL stress_out%0d got=%h exp=%h", n, {out_valid, out_c}, {1'b1, a & b}); end
            guard = 0;
            do begin
                out_ready = ($urandom_range(0, 3) != 0);
                hs = out_ready;
                tick();
                guard++;
            end while (!hs && guard < 64);
            out_ready = 1'b0;
        end
        for (int n = 0; n < N_STRESS; n++) begin
            ones_ma += $countones(rec_ma[n]);
            ones_r  += $countones(rec_r[n]);
        end
        $display("stress samples=%0d ma_ones=%0d r_ones=%0d", N_STRESS, ones_ma, ones_r);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_seed();
        test_reset_mid();
        test_stress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
